// File: rtl/aes_byte_loader.sv
// aes_byte_loader: writer end of the byte-serial AES-128 core load interface.
// A 128-bit key and plaintext block are accepted over valid/ready. The loader
// then resets the core for one cycle and streams one key byte and one plaintext
// byte per cycle, most significant byte first. After that it waits for the
// core's sticky data-valid flag, or gives up after TIMEOUT cycles, and pulses
// done together with a timeout_err qualifier.
module aes_byte_loader #(
    parameter int NBYTES  = 16,
    parameter int TIMEOUT = 2048,
    parameter int TW      = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [127:0] in_pt,
    output logic         core_rst,
    output logic [7:0]   key_byte,
    output logic [7:0]   data_byte,
    input  logic         core_vld,
    output logic         busy,
    output logic         done,
    output logic         timeout_err
);

    localparam int BW = $clog2(NBYTES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CRST = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t          state_r;
    logic [BW-1:0]   byte_cnt_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [127:0]    key_r;
    logic [127:0]    pt_r;
    logic            err_r;
    logic [6:0]      bit_lo_s;

    // Sequencer: capture the request, reset the core, stream bytes, wait for the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            byte_cnt_r <= '0;
            tmo_cnt_r  <= '0;
            key_r      <= '0;
            pt_r       <= '0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // in_ready is high here, so in_valid alone completes the handshake.
                    if (in_valid) begin
                        key_r   <= in_key;
                        pt_r    <= in_pt;
                        state_r <= CRST;
                    end
                end
                CRST: begin
                    byte_cnt_r <= '0;
                    state_r    <= LOAD;
                end
                LOAD: begin
                    if (byte_cnt_r == BW'(NBYTES - 1)) begin
                        byte_cnt_r <= '0;
                        tmo_cnt_r  <= '0;
                        state_r    <= RUN;
                    end else begin
                        byte_cnt_r <= byte_cnt_r + {{(BW-1){1'b0}}, 1'b1};
                    end
                end
                RUN: begin
                    // A valid flag in the same cycle as the last timeout count wins.
                    if (core_vld) begin
                        err_r   <= 1'b0;
                        state_r <= FIN;
                    end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
                        err_r   <= 1'b1;
                        state_r <= FIN;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Byte lane offset of the current LOAD byte; byte 0 is the top byte.
    always_comb begin
        bit_lo_s = 7'(8 * (NBYTES - 1 - int'(byte_cnt_r)));
    end

    // Output decode from registered state; rst forces the reset-time values immediately.
    always_comb begin
        in_ready    = 1'b0;
        core_rst    = 1'b1;
        key_byte    = 8'h00;
        data_byte   = 8'h00;
        busy        = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        if (rst) begin
            core_rst = 1'b1;
        end else begin
            in_ready    = (state_r == IDLE);
            core_rst    = (state_r == CRST);
            busy        = (state_r != IDLE);
            done        = (state_r == FIN);
            timeout_err = (state_r == FIN) && err_r;
            if (state_r == LOAD) begin
                key_byte  = key_r[bit_lo_s +: 8];
                data_byte = pt_r[bit_lo_s +: 8];
            end else begin
                key_byte  = 8'h00;
                data_byte = 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Self-checking bench for aes_byte_loader. A transaction-level reference model
// predicts, cycle by cycle after each accepted request, the core reset pulse,
// the byte stream taken from the request words, and the done/timeout_err
// outcome from the delay at which the emulated core raises its valid flag.
module tb_aes_byte_loader;

    localparam int TIMEOUT = 2048;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_pt;
    logic         core_rst;
    logic [7:0]   key_byte;
    logic [7:0]   data_byte;
    logic         core_vld;
    logic         busy;
    logic         done;
    logic         timeout_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_byte_loader #(.NBYTES(16), .TIMEOUT(TIMEOUT), .TW(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_key      (in_key),
        .in_pt       (in_pt),
        .core_rst    (core_rst),
        .key_byte    (key_byte),
        .data_byte   (data_byte),
        .core_vld    (core_vld),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte i of a 128-bit block, byte 0 being the most significant.
    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        logic [127:0] sh;
        sh = v >> (8 * (15 - i));
        return sh[7:0];
    endfunction

    // One request, entered in an IDLE cycle just after a rising edge.
    // d: RUN cycle index at which the emulated core raises valid (>= TIMEOUT: never).
    task automatic do_job(input logic [127:0] k, input logic [127:0] p, input int d,
                          input bit force_vld, input bit keep_valid);
        int         fo;
        bit         exp_err;
        bit         in_load;
        logic [7:0] ek;
        logic [7:0] ed;
        if (force_vld) fo = 19;
        else if (d < TIMEOUT) fo = 19 + d;
        else fo = 18 + TIMEOUT;
        exp_err = !force_vld && (d >= TIMEOUT);
        in_key   = k;
        in_pt    = p;
        in_valid = 1'b1;
        if (force_vld) core_vld = 1'b1;
        @(negedge clk);
        check_eq("ready_idle", in_ready, 1'b1);
        check_eq("busy_idle", busy, 1'b0);
        check_eq("done_idle", done, 1'b0);
        @(posedge clk);
        #1;
        // Inputs after acceptance must not leak into the job.
        in_key = {$urandom, $urandom, $urandom, $urandom};
        in_pt  = {$urandom, $urandom, $urandom, $urandom};
        if (!keep_valid) in_valid = 1'b0;
        for (int c = 1; c <= fo; c++) begin
            if (force_vld) core_vld = 1'b1;
            else if (c == 1) core_vld = 1'($urandom_range(0, 1));
            else core_vld = (c >= 18 + d);
            in_load = (c >= 2) && (c <= 17);
            ek = in_load ? byte_of(k, c - 2) : 8'h00;
            ed = in_load ? byte_of(p, c - 2) : 8'h00;
            @(negedge clk);
            check_eq($sformatf("core_rst@%0d", c), core_rst, (c == 1));
            check_eq($sformatf("key_byte@%0d", c), key_byte, ek);
            check_eq($sformatf("data_byte@%0d", c), data_byte, ed);
            check_eq($sformatf("busy@%0d", c), busy, 1'b1);
            check_eq($sformatf("in_ready@%0d", c), in_ready, 1'b0);
            check_eq($sformatf("done@%0d", c), done, (c == fo));
            check_eq($sformatf("timeout_err@%0d", c), timeout_err, (c == fo) && exp_err);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [127:0] k;
        logic [127:0] p;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_key   = '0;
        in_pt    = '0;
        core_vld = 1'b0;
        repeat (3) @(posedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_core_rst", core_rst, 1'b1);
        check_eq("rst_key_byte", key_byte, 8'h00);
        check_eq("rst_data_byte", data_byte, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_timeout_err", timeout_err, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_core_rst", core_rst, 1'b0);
        @(posedge clk);
        #1;

        // Directed vectors, core answers 144 cycles into RUN.
        do_job(128'h000102030405060708090A0B0C0D0E0F,
               128'h00112233445566778899AABBCCDDEEFF, 144, 1'b0, 1'b0);
        // Core never answers: timeout.
        do_job({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, TIMEOUT, 1'b0, 1'b0);
        // Core answers on the last timeout cycle: valid wins.
        do_job({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, TIMEOUT - 1, 1'b0, 1'b0);

        // Reset during LOAD byte 7.
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        in_key   = k;
        in_pt    = p;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_eq("mid_key_byte7", key_byte, byte_of(k, 7));
        check_eq("mid_data_byte7", data_byte, byte_of(p, 7));
        rst = 1'b1;
        #1;
        check_eq("mid_rst_core_rst", core_rst, 1'b1);
        check_eq("mid_rst_key_byte", key_byte, 8'h00);
        check_eq("mid_rst_in_ready", in_ready, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_key_byte", key_byte, 8'h00);
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        check_eq("post_rst_core_rst", core_rst, 1'b0);
        check_eq("post_rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // Random blocks with random core latency.
        for (int j = 0; j < 5; j++) begin
            do_job({$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom},
                   int'($urandom_range(0, 300)), 1'b0, 1'b0);
        end

        // core_vld tied high, in_valid held: back-to-back requests.
        do_job({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, 1'b1);
        do_job({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, 1'b0);
        core_vld = 1'b0;
        @(negedge clk);
        check_eq("final_in_ready", in_ready, 1'b1);
        check_eq("final_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
